// File: rtl/sdram_frame_bank_ctrl.sv
// Triple-buffer bank scheduler for the two-FIFO SDRAM frame store.
// It picks the write and read banks, generates the address-load pulses and counts dropped and repeated frames.
module sdram_frame_bank_ctrl #(
  parameter int BANK_NUM    = 3,
  parameter int LOAD_CYCLES = 4
) (
  input  logic        clk_ref,
  input  logic        rst_n,
  input  logic        sdram_init_done,
  input  logic        frame_write_done,
  input  logic        rd_frame_req,
  output logic [1:0]  wr_bank,
  output logic [1:0]  rd_bank,
  output logic        wr_load,
  output logic        rd_load,
  output logic        frame_valid,
  output logic [15:0] drop_cnt,
  output logic [15:0] repeat_cnt
);

  typedef enum logic [1:0] {S_INIT, S_LOAD, S_RUN} state_t;

  localparam logic [3:0]  LOAD_LAST = 4'(LOAD_CYCLES - 1);
  localparam logic [1:0]  LAST_BANK = 2'(BANK_NUM - 1);
  localparam logic [15:0] CNT_MAX   = 16'hFFFF;

  state_t     state;
  logic [3:0] load_cnt;
  logic [3:0] wr_pcnt;
  logic [3:0] rd_pcnt;
  logic [1:0] latest;
  logic       latest_vld;
  logic       new_flag;

  logic       wr_ev;
  logic       rd_ev;
  logic [1:0] next_wr;

  // Lowest bank index that differs from both a and b.
  function automatic logic [1:0] pick_bank(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] r;
    r = '0;
    for (int i = BANK_NUM - 1; i >= 0; i--) begin
      if (2'(i) != a && 2'(i) != b) r = 2'(i);
    end
    return r;
  endfunction

  assign wr_ev = (state == S_RUN) && frame_write_done;
  assign rd_ev = (state == S_RUN) && rd_frame_req;

  // With a simultaneous read, the reader takes the just-completed bank, so only that one is excluded.
  assign next_wr = pick_bank(wr_bank, rd_ev ? wr_bank : rd_bank);

  assign frame_valid = latest_vld;

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state      <= S_INIT;
      load_cnt   <= '0;
      wr_pcnt    <= '0;
      rd_pcnt    <= '0;
      wr_bank    <= '0;
      rd_bank    <= LAST_BANK;
      wr_load    <= 1'b0;
      rd_load    <= 1'b0;
      latest     <= '0;
      latest_vld <= 1'b0;
      new_flag   <= 1'b0;
      drop_cnt   <= '0;
      repeat_cnt <= '0;
    end else begin
      case (state)
        S_INIT: begin
          if (sdram_init_done) begin
            state    <= S_LOAD;
            load_cnt <= '0;
          end
        end

        S_LOAD: begin
          wr_load <= 1'b1;
          rd_load <= 1'b1;
          wr_pcnt <= '0;
          rd_pcnt <= '0;
          if (load_cnt == LOAD_LAST) state <= S_RUN;
          else                       load_cnt <= load_cnt + 4'd1;
        end

        S_RUN: begin
          // A new event restarts the pulse rather than queueing a second one.
          if (wr_ev) begin
            wr_pcnt <= LOAD_LAST;
            wr_load <= 1'b1;
          end else if (wr_pcnt != '0) begin
            wr_pcnt <= wr_pcnt - 4'd1;
            wr_load <= 1'b1;
          end else begin
            wr_load <= 1'b0;
          end

          if (rd_ev) begin
            rd_pcnt <= LOAD_LAST;
            rd_load <= 1'b1;
          end else if (rd_pcnt != '0) begin
            rd_pcnt <= rd_pcnt - 4'd1;
            rd_load <= 1'b1;
          end else begin
            rd_load <= 1'b0;
          end

          if (wr_ev) begin
            latest     <= wr_bank;
            latest_vld <= 1'b1;
            wr_bank    <= next_wr;
            if (rd_ev) begin
              rd_bank  <= wr_bank;
              new_flag <= 1'b0;
            end else begin
              new_flag <= 1'b1;
              if (new_flag && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 16'd1;
            end
          end else if (rd_ev) begin
            if (new_flag) begin
              rd_bank  <= latest;
              new_flag <= 1'b0;
            end else if (latest_vld && repeat_cnt != CNT_MAX) begin
              repeat_cnt <= repeat_cnt + 16'd1;
            end
          end
        end

        default: state <= S_INIT;
      endcase
    end
  end

endmodule
